ultrasonic_ranger: RTL and testbench

Drives an HC-SR04-style ultrasonic sensor and converts each echo pulse width into a 16-bit distance in centimetres. It fires a trigger pulse periodically, times the echo, and presents the result on a register that feeds pio_3_external_connection_export of radar_core, where the NIOS II reads it. This block is the producer end of the distance interface that the processor reads.

---
 rtl/ultrasonic_ranger.sv | 157 +++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger pulse, echo pulse timing, distance in cm.
// 16'hFFFF on distance_export means "no target" (timeout in either wait phase).
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int CM_DIV         = 2900,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic        echo_in,
  output logic        trig_out,
  output logic [15:0] distance_export,
  output logic        sample_valid,
  output logic        timeout_flag,
  output logic        busy
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(PERIOD_CYCLES);
  localparam int SW      = $clog2(CM_DIV);

  localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST     = SW'(CM_DIV - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_echo_meta;
  logic          r_echo_s;
  logic          r_echo_prev;
  logic [PW-1:0] r_period;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sub;
  logic [15:0]   r_cm;
  logic [15:0]   r_distance;
  logic          r_timeout;
  logic          w_rise;
  logic          w_fall;
  logic          w_done;
  logic          w_timed_out;

  assign w_rise = r_echo_s & ~r_echo_prev;
  assign w_fall = ~r_echo_s & r_echo_prev;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_prev <= 1'b0;
    end else begin
      r_echo_meta <= echo_in;
      r_echo_s    <= r_echo_meta;
      r_echo_prev <= r_echo_s;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                r_period <= '0;
    else if (!enable)                  r_period <= '0;
    else if (r_period == PERIOD_LAST)  r_period <= '0;
    else                               r_period <= r_period + PW'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_done      = 1'b0;
    w_timed_out = 1'b0;
    case (r_state)
      IDLE:      if (enable && r_period == '0) w_next = TRIG;
      TRIG:      if (r_cnt == TRIG_LAST) w_next = WAIT_RISE;
      WAIT_RISE: begin
        if (w_rise) begin
          w_next = MEASURE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next      = DONE;
          w_done      = 1'b1;
          w_timed_out = 1'b1;
        end
      end
      MEASURE: begin
        if (w_fall) begin
          w_next = DONE;
          w_done = 1'b1;
        end else if (r_echo_s && r_cnt == TIMEOUT_LAST) begin
          w_next      = DONE;
          w_done      = 1'b1;
          w_timed_out = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The rising-edge cycle already has echo high, so it is counted as the first high cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt <= '0;
      r_sub <= '0;
      r_cm  <= '0;
    end else begin
      case (r_state)
        TRIG:      r_cnt <= (r_cnt == TRIG_LAST) ? '0 : r_cnt + CW'(1);
        WAIT_RISE: begin
          if (w_rise) begin
            r_cnt <= CW'(1);
            r_sub <= SW'(1);
            r_cm  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MEASURE: begin
          if (r_echo_s) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_sub == SUB_LAST) begin
              r_sub <= '0;
              if (r_cm != 16'hFFFE) r_cm <= r_cm + 16'd1;
            end else begin
              r_sub <= r_sub + SW'(1);
            end
          end
        end
        default:   r_cnt <= '0;
      endcase
    end
  end

  // Result is loaded on entry to DONE so it is stable while sample_valid is high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_distance <= 16'hFFFF;
      r_timeout  <= 1'b0;
    end else if (w_done) begin
      r_distance <= w_timed_out ? 16'hFFFF : r_cm;
      r_timeout  <= w_timed_out;
    end
  end

  assign trig_out        = (r_state == TRIG);
  assign sample_valid    = (r_state == DONE);
  assign busy            = (r_state != IDLE);
  assign distance_export = r_distance;
  assign timeout_flag    = r_timeout;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger: directed scenarios plus randomized echo
// pulses compared against a width-to-distance reference model.
module tb_ultrasonic_ranger;

  localparam int TRIG    = 4;
  localparam int PERIOD  = 400;
  localparam int CM_DIV  = 10;
  localparam int TIMEOUT = 150;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic        echo_in;
  logic        trig_out;
  logic [15:0] distance_export;
  logic        sample_valid;
  logic        timeout_flag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int validCount = 0;
  logic [15:0] capDist = 16'h0;
  logic        capTimeout = 1'b0;
  int lastStart = 0;

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD), .CM_DIV(CM_DIV), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .echo_in(echo_in),
    .trig_out(trig_out), .distance_export(distance_export), .sample_valid(sample_valid),
    .timeout_flag(timeout_flag), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  // Records every result presented with sample_valid.
  always @(negedge clk_clk) begin
    cycleCount <= cycleCount + 1;
    if (sample_valid) begin
      validCount <= validCount + 1;
      capDist    <= distance_export;
      capTimeout <= timeout_flag;
    end
  end

  function automatic logic [16:0] refModel(input int width);
    if (width == 0 || width >= TIMEOUT) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(width / CM_DIV)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk_clk);
    #1;
  endtask

  // Waits for a trigger, optionally checks the period, and steps through the pulse.
  task automatic startTrig(input bit checkPeriod, output int waited);
    int w;
    bit found;
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 500) begin
      step();
      waited++;
      if (trig_out) found = 1'b1;
    end
    checkOutput("trigArrive", found, 1);
    if (checkPeriod) checkOutput("period", cycleCount - lastStart, PERIOD);
    lastStart = cycleCount;
    checkOutput("busyTrig", busy, 1);
    w = 1;
    while (w < 50) begin
      step();
      if (!trig_out) break;
      w++;
    end
    checkOutput("trigWidth", w, TRIG);
  endtask

  task automatic applyStimulus(input int delay, input int width);
    int v0;
    int budget;
    logic [16:0] exp;
    v0 = validCount;
    if (width > 0) begin
      repeat (delay) step();
      echo_in = 1'b1;
      repeat (width) step();
      echo_in = 1'b0;
    end
    budget = 0;
    while (validCount == v0 && budget < 400) begin
      step();
      budget++;
    end
    repeat (3) step();
    exp = refModel(width);
    checkOutput("sampleCount", validCount - v0, 1);
    checkOutput("distance", capDist, exp[15:0]);
    checkOutput("timeoutFlag", capTimeout, exp[16]);
    checkOutput("busyIdle", busy, 0);
  endtask

  task automatic runMeasurement(input int delay, input int width);
    int waited;
    startTrig(1'b1, waited);
    applyStimulus(delay, width);
  endtask

  initial begin
    int waited;
    int k;
    int v1;
    int sawTrig;
    int kind;
    int width;
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    echo_in       = 1'b0;
    repeat (3) step();
    checkOutput("rstTrig", trig_out, 0);
    checkOutput("rstDist", distance_export, 16'hFFFF);
    checkOutput("rstValid", sample_valid, 0);
    checkOutput("rstTimeout", timeout_flag, 0);
    checkOutput("rstBusy", busy, 0);

    $display("[TB] no echo: wait-rise timeout");
    enable        = 1'b1;
    reset_reset_n = 1'b1;
    startTrig(1'b0, waited);
    checkOutput("firstTrig", waited, 1);
    k = 0;
    while (!sample_valid && k < 300) begin
      step();
      k++;
    end
    checkOutput("waitRiseCycles", k, TIMEOUT);
    checkOutput("waitDist", distance_export, 16'hFFFF);
    checkOutput("waitTimeout", timeout_flag, 1);
    step();
    checkOutput("validOneCycle", sample_valid, 0);

    $display("[TB] echo 57 cycles");
    runMeasurement(20, 57);

    $display("[TB] stale echo high");
    v1 = validCount;
    startTrig(1'b1, waited);
    repeat (20) step();
    echo_in = 1'b1;
    k = 0;
    while (validCount == v1 && k < 300) begin
      step();
      k++;
    end
    checkOutput("longDist", capDist, 16'hFFFF);
    checkOutput("longTimeout", capTimeout, 1);
    v1 = validCount;
    startTrig(1'b1, waited);
    repeat (30) step();
    checkOutput("staleNoSample", validCount - v1, 0);
    checkOutput("staleBusy", busy, 1);
    echo_in = 1'b0;
    applyStimulus(20, 57);

    $display("[TB] enable dropped during measure");
    startTrig(1'b1, waited);
    repeat (20) step();
    echo_in = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    v1 = validCount;
    repeat (20) step();
    echo_in = 1'b0;
    repeat (6) step();
    checkOutput("disSampleCount", validCount - v1, 1);
    checkOutput("disDist", capDist, 16'd3);
    sawTrig = 0;
    repeat (900) begin
      step();
      if (trig_out) sawTrig++;
    end
    checkOutput("noTrigDisabled", sawTrig, 0);

    $display("[TB] reset during trigger");
    enable = 1'b1;
    startTrig(1'b0, waited);
    checkOutput("enableTrig", waited, 1);
    runMeasurement(5, 40);
    v1 = 0;
    k = 0;
    while (!trig_out && k < 500) begin
      step();
      k++;
    end
    step();
    reset_reset_n = 1'b0;
    #1;
    checkOutput("midRstTrig", trig_out, 0);
    checkOutput("midRstDist", distance_export, 16'hFFFF);
    checkOutput("midRstBusy", busy, 0);
    repeat (2) step();
    reset_reset_n = 1'b1;
    startTrig(1'b0, waited);
    checkOutput("postRstTrig", waited, 1);
    applyStimulus(10, 95);

    $display("[TB] back-to-back periods and boundaries");
    for (int i = 0; i < 3; i++) runMeasurement(15, 95);
    runMeasurement(10, 149);
    runMeasurement(10, 150);

    $display("[TB] randomized echoes");
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0)      width = 0;
      else if (kind == 1) width = $urandom_range(150, 200);
      else                width = $urandom_range(1, 149);
      runMeasurement($urandom_range(5, 100), width);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
